// File: rtl/hazard_sequencer.sv
// hazard_sequencer: central stall/flush controller for the two-stage
// fetch/decode -> execute/memory pipeline. One FSM sequences load-use
// bubbles, multi-cycle memory waits (with timeout) and branch/JAL redirects.
//
// Optional build macro: HAZARD_PERF_CNT_EN
//   defined   -> stallCount/flushCount are saturating 16-bit event counters
//   undefined -> both outputs are tied to zero
module hazard_sequencer #(
    parameter logic [3:0] OP1_LW      = 4'b1001,
    parameter logic [3:0] OP1_BR      = 4'b0010,
    parameter logic [3:0] OP1_JAL     = 4'b1011,
    parameter int         MEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  idRdIndex1,
    input  logic [3:0]  idRdIndex2,
    input  logic        idUsesRd1,
    input  logic        idUsesRd2,
    input  logic [3:0]  exWrtIndex,
    input  logic        exRegWrEn,
    input  logic [3:0]  exInstType,
    input  logic        exBrTaken,
    input  logic        exIsLoad,
    input  logic        exIsStore,
    input  logic        memAck,
    output logic        stallF,
    output logic        stallD,
    output logic        holdE,
    output logic        bubbleE,
    output logic        flushD,
    output logic        memErr,
    output logic [1:0]  seqState,
    output logic [15:0] stallCount,
    output logic [15:0] flushCount
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LOAD_USE = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RECOVER  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_next;
    // Low for the first cycle after reset so outputs stay quiet until the
    // FSM has had one clean evaluation point.
    logic       r_armed;

    logic w_redirect;
    logic w_mem_op;
    logic w_load_use;
    logic w_rd1_hit;
    logic w_rd2_hit;

    assign w_redirect = (exInstType == OP1_JAL) ||
                        ((exInstType == OP1_BR) && exBrTaken);
    assign w_mem_op   = (exIsLoad || exIsStore) && !memAck;
    assign w_rd1_hit  = idUsesRd1 && (exWrtIndex == idRdIndex1);
    assign w_rd2_hit  = idUsesRd2 && (exWrtIndex == idRdIndex2);
    assign w_load_use = exRegWrEn && (exInstType == OP1_LW) &&
                        (exWrtIndex != 4'd0) && (w_rd1_hit || w_rd2_hit);

    assign seqState = r_state;

    // Next-state and control-output decode from current state and inputs
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        stallF          = 1'b0;
        stallD          = 1'b0;
        holdE           = 1'b0;
        bubbleE         = 1'b0;
        flushD          = 1'b0;
        memErr          = 1'b0;
        if (!reset && r_armed) begin
            case (r_state)
                ST_RUN: begin
                    if (w_redirect) begin
                        flushD       = 1'b1;
                        w_state_next = ST_RECOVER;
                    end else if (w_mem_op) begin
                        stallF          = 1'b1;
                        stallD          = 1'b1;
                        holdE           = 1'b1;
                        w_state_next    = ST_MEM_WAIT;
                        w_wait_cnt_next = 8'd1;
                    end else if (w_load_use) begin
                        stallF       = 1'b1;
                        stallD       = 1'b1;
                        bubbleE      = 1'b1;
                        w_state_next = ST_LOAD_USE;
                    end
                end
                ST_LOAD_USE: begin
                    // The bubble cycle never re-detects load-use, but a memory
                    // access now in execute still has to be waited on.
                    if (w_mem_op) begin
                        stallF          = 1'b1;
                        stallD          = 1'b1;
                        holdE           = 1'b1;
                        w_state_next    = ST_MEM_WAIT;
                        w_wait_cnt_next = 8'd1;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (memAck) begin
                        w_state_next = ST_RUN;
                    end else if (r_wait_cnt >= TIMEOUT_CNT) begin
                        memErr       = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        stallF          = 1'b1;
                        stallD          = 1'b1;
                        holdE           = 1'b1;
                        w_wait_cnt_next = r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    // RECOVER: the refetched instruction is not checked
                    // against the squashed one.
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    // State, wait counter and arm flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_armed    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_armed    <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Saturating stall/flush event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (stallF && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (flushD && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stallCount = r_stall_cnt;
    assign flushCount = r_flush_cnt;
`else
    assign stallCount = 16'd0;
    assign flushCount = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed testbench for hazard_sequencer. Expected output vectors are queued
// as each step is driven and popped for comparison mid-cycle.
module tb_hazard_sequencer;

    localparam logic [3:0] LW  = 4'b1001;
    localparam logic [3:0] BR  = 4'b0010;
    localparam logic [3:0] JAL = 4'b1011;
    localparam logic [3:0] ALU = 4'b0000;

    // flag order: {stallF, stallD, holdE, bubbleE, flushD, memErr}
    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] LU = 6'b110100;
    localparam logic [5:0] MW = 6'b111000;
    localparam logic [5:0] FL = 6'b000010;
    localparam logic [5:0] ER = 6'b000001;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  idRdIndex1, idRdIndex2, exWrtIndex, exInstType;
    logic        idUsesRd1, idUsesRd2, exRegWrEn, exBrTaken;
    logic        exIsLoad, exIsStore, memAck;
    logic        stallF, stallD, holdE, bubbleE, flushD, memErr;
    logic [1:0]  seqState;
    logic [15:0] stallCount, flushCount;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] stall_model = 16'd0;
    logic [15:0] flush_model = 16'd0;

    always #5 clk = ~clk;

    hazard_sequencer #(
        .OP1_LW(LW), .OP1_BR(BR), .OP1_JAL(JAL), .MEM_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .idRdIndex1(idRdIndex1), .idRdIndex2(idRdIndex2),
        .idUsesRd1(idUsesRd1), .idUsesRd2(idUsesRd2),
        .exWrtIndex(exWrtIndex), .exRegWrEn(exRegWrEn),
        .exInstType(exInstType), .exBrTaken(exBrTaken),
        .exIsLoad(exIsLoad), .exIsStore(exIsStore), .memAck(memAck),
        .stallF(stallF), .stallD(stallD), .holdE(holdE), .bubbleE(bubbleE),
        .flushD(flushD), .memErr(memErr), .seqState(seqState),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    function automatic logic [7:0] e(input logic [1:0] s, input logic [5:0] f);
        return {s, f};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic [3:0] ty,
                        input logic we, input logic [3:0] wi,
                        input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2,
                        input logic bt, input logic ld, input logic st,
                        input logic ack, input logic [7:0] expv);
        logic [7:0] want;
        @(posedge clk);
        #1;
        reset = rst; exInstType = ty; exRegWrEn = we; exWrtIndex = wi;
        idRdIndex1 = r1; idUsesRd1 = u1; idRdIndex2 = r2; idUsesRd2 = u2;
        exBrTaken = bt; exIsLoad = ld; exIsStore = st; memAck = ack;
        exp_q.push_back(expv);
        @(negedge clk);
        want = exp_q.pop_front();
        $display("step %-10s seq=%0d flags=%b exp seq=%0d flags=%b", tag,
                 seqState, {stallF, stallD, holdE, bubbleE, flushD, memErr},
                 want[7:6], want[5:0]);
        chk(tag, {8'd0, seqState, stallF, stallD, holdE, bubbleE, flushD, memErr},
            {8'd0, want});
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_scnt"}, stallCount, stall_model);
        chk({tag, "_fcnt"}, flushCount, flush_model);
`else
        chk({tag, "_scnt"}, stallCount, 16'd0);
        chk({tag, "_fcnt"}, flushCount, 16'd0);
`endif
        if (rst) begin
            stall_model = 16'd0;
            flush_model = 16'd0;
        end else begin
            stall_model = stall_model + 16'(want[5]);
            flush_model = flush_model + 16'(want[1]);
        end
    endtask

    task automatic idle(input string tag, input logic [7:0] expv);
        step(tag, 1'b0, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b1, expv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; exInstType = ALU; exRegWrEn = 1'b0; exWrtIndex = 4'd0;
        idRdIndex1 = 4'd0; idRdIndex2 = 4'd0; idUsesRd1 = 1'b0; idUsesRd2 = 1'b0;
        exBrTaken = 1'b0; exIsLoad = 1'b0; exIsStore = 1'b0; memAck = 1'b1;
        repeat (2) @(posedge clk);

        // Reset cycle, then the quiet cycle after release even with a hazard present
        step("rst", 1'b1, LW, 1'b1, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e(0, Z));
        step("unarmed", 1'b0, LW, 1'b1, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e(0, Z));

        // Load-use on rs1: one bubble, no re-detect in LOAD_USE
        step("lu_rs1", 1'b0, LW, 1'b1, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e(0, LU));
        step("lu_hold", 1'b0, LW, 1'b1, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(1, Z));
        idle("lu_done", e(0, Z));

        // Load-use on rs2; unused operand match ignored; r0 destination ignored
        step("lu_rs2", 1'b0, LW, 1'b1, 4'd7, 4'd1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, e(0, LU));
        idle("lu2_ls", e(1, Z));
        step("unused", 1'b0, LW, 1'b1, 4'd7, 4'd7, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e(0, Z));
        step("reg0", 1'b0, LW, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, e(0, Z));
        step("no_we", 1'b0, LW, 1'b0, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e(0, Z));

        // Load with three cycles of no ack, then ack
        step("mw_run", 1'b0, LW, 1'b1, 4'd3, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e(0, MW));
        step("mw_w1", 1'b0, LW, 1'b1, 4'd3, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e(2, MW));
        step("mw_w2", 1'b0, LW, 1'b1, 4'd3, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e(2, MW));
        step("mw_ack", 1'b0, LW, 1'b1, 4'd3, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, e(2, Z));
        idle("mw_done", e(0, Z));

        // Store acked immediately is a zero-stall access
        step("st_fast", 1'b0, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, e(0, Z));

        // Timeout: memErr on the 8th MEM_WAIT cycle, stalls drop that cycle
        step("to_run", 1'b0, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e(0, MW));
        for (int i = 0; i < 7; i++) begin
            step("to_wait", 1'b0, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e(2, MW));
        end
        step("to_err", 1'b0, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e(2, ER));
        idle("to_done", e(0, Z));

        // Taken branch with matching indices and a pending memory op: redirect wins
        step("br_taken", 1'b0, BR, 1'b1, 4'd5, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, e(0, FL));
        step("br_recov", 1'b0, LW, 1'b1, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(3, Z));
        idle("br_done", e(0, Z));
        step("br_ntkn", 1'b0, BR, 1'b0, 4'd0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(0, Z));
        step("jal", 1'b0, JAL, 1'b1, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(0, FL));
        idle("jal_recov", e(3, Z));
        idle("jal_done", e(0, Z));

        // Memory op arriving during the load-use bubble cycle
        step("lu_then", 1'b0, LW, 1'b1, 4'd4, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e(0, LU));
        step("lu_memop", 1'b0, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(1, MW));
        step("lu_mwack", 1'b0, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e(2, Z));
        idle("lu_mwdone", e(0, Z));

        // Reset during MEM_WAIT: quiet, back to RUN, no memErr afterwards
        step("rw_run", 1'b0, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(0, MW));
        step("rw_wait", 1'b0, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(2, MW));
        step("rw_rst", 1'b1, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(2, Z));
        step("rw_after", 1'b0, ALU, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(0, Z));
        for (int i = 0; i < 10; i++) begin
            idle("rw_quiet", e(0, Z));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central stall/flush controller for the two-stage fetch/decode → execute/memory pipeline.
- Inputs: decode-stage read indices and the execute-stage register outputs (write index, write enable, instruction type, branch-taken, load/store flags), plus the data-memory acknowledge.
- Sequences load-use bubbles, multi-cycle memory waits with timeout, and branch/JAL redirects through one FSM.
- Replaces the per-register ad-hoc stall logic with a single point of control.

Parameters:
- OP1_LW, 4'b1001, opcode class of load word
- OP1_BR, 4'b0010, opcode class of conditional branch
- OP1_JAL, 4'b1011, opcode class of jump-and-link
- MEM_TIMEOUT, 8, max cycles spent in MEM_WAIT before forced release (1..255)

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- idRdIndex1  in  4  decode-stage source register 1
- idRdIndex2  in  4  decode-stage source register 2
- idUsesRd1  in  1  decode instruction reads idRdIndex1
- idUsesRd2  in  1  decode instruction reads idRdIndex2
- exWrtIndex  in  4  execute-stage destination register
- exRegWrEn  in  1  execute-stage register write enable
- exInstType  in  4  execute-stage opcode class
- exBrTaken  in  1  execute-stage branch resolved taken
- exIsLoad  in  1  execute-stage instruction is a load
- exIsStore  in  1  execute-stage instruction is a store
- memAck  in  1  data memory completes access this cycle
- stallF  out  1  hold PC / fetch
- stallD  out  1  hold decode register
- holdE  out  1  hold execute register contents
- bubbleE  out  1  clear RegWrEn/IsLoad/IsStore entering execute
- flushD  out  1  squash decode instruction
- memErr  out  1  one-cycle pulse on memory timeout
- seqState  out  2  current FSM state
- stallCount  out  16  saturating stalled-cycle counter (optional)
- flushCount  out  16  saturating flush counter (optional)

Behaviour:
- Reset values:
  - state = RUN (2'd0); waitCnt = 0; counters = 0.
  - All control outputs are 0 in the reset cycle and the cycle after reset deasserts, until the FSM evaluates.
- States: RUN = 0, LOAD_USE = 1, MEM_WAIT = 2, RECOVER = 3.
- Outputs are combinational from state and the current inputs; state registers on posedge.
- RUN, evaluated in priority order:
  1. Redirect: exInstType == OP1_JAL, or (exInstType == OP1_BR && exBrTaken).
     - flushD = 1; next state RECOVER.
     - Load-use and memory checks are ignored this cycle.
  2. Memory op: (exIsLoad | exIsStore) && !memAck.
     - stallF = stallD = holdE = 1; next state MEM_WAIT; waitCnt <= 1.
  3. Load-use: exRegWrEn && exInstType == OP1_LW && exWrtIndex != 0 && ((idUsesRd1 && exWrtIndex == idRdIndex1) || (idUsesRd2 && exWrtIndex == idRdIndex2)).
     - stallF = stallD = bubbleE = 1; next state LOAD_USE.
  4. Otherwise: all outputs 0; stay in RUN.
- LOAD_USE:
  - Exactly one cycle; no hazard is re-detected (no back-to-back double stall).
  - Outputs 0 except when the memory-op condition holds; then MEM_WAIT rules apply.
  - Otherwise next state RUN.
- MEM_WAIT:
  - stallF = stallD = holdE = 1 while memAck = 0; waitCnt increments.
  - memAck = 1: stalls deassert in that same cycle; next state RUN.
  - waitCnt == MEM_TIMEOUT with no memAck: memErr = 1 for one cycle, stalls deassert, next state RUN.
  - A redirect cannot occur here because execute is held.
- RECOVER:
  - One cycle with all outputs 0; next state RUN.
  - Guarantees the refetched instruction is not hazard-checked against the squashed one.
- Simultaneous events:
  - Redirect beats memory op, which beats load-use.
  - memAck arriving in RUN with a memory op is a zero-stall access.
- Reset mid-operation: returns to RUN on the next edge regardless of state; waitCnt is cleared; a pending memErr is not issued.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stallCount increments each cycle stallF = 1.
  - flushCount increments each cycle flushD = 1.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Test Plan:
- Load-use: exInstType = OP1_LW, exRegWrEn = 1, exWrtIndex = 5, idRdIndex1 = 5, idUsesRd1 = 1 → stallF/stallD/bubbleE = 1 for exactly 1 cycle, seqState 0→1→0.
- Load with memAck held 0 for 3 cycles, then 1 → stallF/holdE = 1 for 3 cycles, deassert on the ack cycle, seqState = 2 during the wait.
- Timeout: memAck never asserts, MEM_TIMEOUT = 8 → memErr pulses once on the 8th wait cycle, then seqState = 0.
- Taken branch (OP1_BR, exBrTaken = 1) coincident with a load-use match → flushD = 1, no stall, seqState 0→3→0; JAL gives the same result.
- Reset asserted during MEM_WAIT → seqState = 0 and all outputs 0 on the next cycle, memErr never pulses; with HAZARD_PERF_CNT_EN, counters read 0.
- Register 0 destination: exWrtIndex = 0 matching idRdIndex1 = 0 → no stall.
